// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator (differential delay 1) with identical,
// independent I and Q paths. Decimation R = 2^decim_log2, changeable at run
// time (a change flushes the filter state and restarts settling).
// Optional macro CIC_DECIMATOR_ROUND_EN: round half up before saturating;
// without it the scaled result is truncated (floor) and then saturated.
module cic_decimator #(
  parameter int DSZ       = 16,
  parameter int STAGES    = 4,
  parameter int LOG2_RMAX = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [DSZ-1:0] in_i,
  input  logic signed [DSZ-1:0] in_q,
  input  logic                  in_valid,
  input  logic [2:0]            decim_log2,
  output logic signed [DSZ-1:0] out_i,
  output logic signed [DSZ-1:0] out_q,
  output logic                  out_valid
);
  localparam int W   = DSZ + STAGES * LOG2_RMAX;
  localparam int SW  = $clog2(STAGES * LOG2_RMAX + 1);
  localparam int CW  = LOG2_RMAX;
  localparam int STW = $clog2(STAGES + 1);
  localparam logic [2:0]        MAX_LOG2 = 3'(LOG2_RMAX);
  localparam logic [STW-1:0]    SETTLED  = STW'(STAGES);
  localparam logic signed [W:0] SAT_HI   = (W+1)'(2**(DSZ-1) - 1);
  localparam logic signed [W:0] SAT_LO   = (W+1)'(-(2**(DSZ-1)));

  logic [2:0]           eff_log2;
  logic [2:0]           prev_log2_reg;
  logic [CW-1:0]        cnt_reg;
  logic [CW-1:0]        r_last;
  logic [SW-1:0]        shift_amt;
  logic [STW-1:0]       settle_reg;
  logic                 flush;
  logic                 strobe;
  logic signed [W-1:0]  comb_i;
  logic signed [W-1:0]  comb_q;

  // Map illegal decimation exponents onto R = 2.
  always_comb begin
    eff_log2 = decim_log2;
    if (decim_log2 == 3'd0 || decim_log2 > MAX_LOG2) eff_log2 = 3'd1;
  end

  assign r_last    = CW'((1 << eff_log2) - 1);
  assign shift_amt = SW'(STAGES * int'(eff_log2));
  // A flushing cycle discards its sample, so it can never strobe.
  assign flush     = (decim_log2 != prev_log2_reg);
  assign strobe    = in_valid && !flush && (cnt_reg == r_last);

  // Track the last sampled rate so a change can be detected one clk later.
  always_ff @(posedge clk) begin
    prev_log2_reg <= decim_log2;
  end

  // Accepted-sample counter 0..R-1; restarts on reset, flush or strobe.
  always_ff @(posedge clk) begin
    if (reset || flush) cnt_reg <= '0;
    else if (in_valid)  cnt_reg <= strobe ? '0 : cnt_reg + CW'(1);
  end

  // Integrator chain: each stage accumulates the previous stage's register.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_int
    logic signed [W-1:0] acc_i_reg, acc_q_reg;
    logic signed [W-1:0] src_i, src_q;
    if (gi == 0) begin : g_first
      assign src_i = W'(in_i);
      assign src_q = W'(in_q);
    end else begin : g_rest
      assign src_i = g_int[gi-1].acc_i_reg;
      assign src_q = g_int[gi-1].acc_q_reg;
    end
    // Wrapping accumulate on accepted samples only.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        acc_i_reg <= '0;
        acc_q_reg <= '0;
      end else if (in_valid) begin
        acc_i_reg <= acc_i_reg + src_i;
        acc_q_reg <= acc_q_reg + src_q;
      end
    end
  end

  // Comb chain at the low rate: y = x - x_delayed, delays advance on strobe.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_comb
    logic signed [W-1:0] dly_i_reg, dly_q_reg;
    logic signed [W-1:0] x_i, x_q, y_i, y_q;
    if (gi == 0) begin : g_first
      assign x_i = g_int[STAGES-1].acc_i_reg;
      assign x_q = g_int[STAGES-1].acc_q_reg;
    end else begin : g_rest
      assign x_i = g_comb[gi-1].y_i;
      assign x_q = g_comb[gi-1].y_q;
    end
    assign y_i = x_i - dly_i_reg;
    assign y_q = x_q - dly_q_reg;
    // Capture this stage's input as the next differential-delay sample.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        dly_i_reg <= '0;
        dly_q_reg <= '0;
      end else if (strobe) begin
        dly_i_reg <= x_i;
        dly_q_reg <= x_q;
      end
    end
  end

  assign comb_i = g_comb[STAGES-1].y_i;
  assign comb_q = g_comb[STAGES-1].y_q;

  // Remove the R^N gain, then clamp to the output range. One guard bit keeps
  // the rounding add from wrapping near full scale.
  function automatic logic signed [DSZ-1:0] scale(input logic signed [W-1:0] x,
                                                   input logic [SW-1:0] sh);
    logic signed [W:0] t;
    t = (W+1)'(x);
`ifdef CIC_DECIMATOR_ROUND_EN
    if (sh != '0) t = t + ((W+1)'(1) <<< (sh - SW'(1)));
`endif
    t = t >>> sh;
    if (t > SAT_HI) t = SAT_HI;
    if (t < SAT_LO) t = SAT_LO;
    return DSZ'(t);
  endfunction

  // Output register plus settling counter; first STAGES strobes are hidden.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_i      <= '0;
      out_q      <= '0;
      out_valid  <= 1'b0;
      settle_reg <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        settle_reg <= '0;
      end else if (strobe) begin
        if (settle_reg == SETTLED) begin
          out_i     <= scale(comb_i, shift_amt);
          out_q     <= scale(comb_q, shift_amt);
          out_valid <= 1'b1;
        end else begin
          settle_reg <= settle_reg + STW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: table-driven DC vectors, hand sequences for rate change,
// reset and impulse, then randomized traffic checked every clk against a
// closed-form CIC reference (binomial integrator sums + N-th differences).
module tb_cic_decimator;
  localparam int DSZ = 16, STAGES = 4, LOG2_RMAX = 6;
  localparam int W = DSZ + STAGES * LOG2_RMAX;

  logic clk = 1'b0;
  logic reset, in_valid;
  logic signed [DSZ-1:0] in_i, in_q, out_i, out_q;
  logic [2:0] decim_log2;
  logic out_valid;

  int checks = 0, errors = 0;

  cic_decimator #(.DSZ(DSZ), .STAGES(STAGES), .LOG2_RMAX(LOG2_RMAX)) dut (
    .clk(clk), .reset(reset), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
    .decim_log2(decim_log2), .out_i(out_i), .out_q(out_q), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  longint hist_i[$], hist_q[$], v_i[$], v_q[$];
  int nstrb;
  logic [2:0] prev_d;
  logic exp_v;
  logic signed [DSZ-1:0] exp_i, exp_q;

  function automatic int eff_of(input logic [2:0] d);
    return (d == 3'd0 || int'(d) > LOG2_RMAX) ? 1 : int'(d);
  endfunction

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    if (k < 0 || n < k) return 0;
    for (int t = 0; t < k; t++) r = r * (n - t) / (t + 1);
    return r;
  endfunction

  // Last integrator register before the current sample j is added:
  // S_N(j) = sum_{i<j} C(j-1-i, N-1) * x[i].
  function automatic longint integ_sum(input bit use_q);
    longint s = 0;
    int j = hist_i.size() - 1;
    for (int i = 0; i < j; i++)
      s += binom(j - 1 - i, STAGES - 1) * (use_q ? hist_q[i] : hist_i[i]);
    return s;
  endfunction

  // N-th difference over the decimated integrator sequence (zero before start).
  function automatic longint comb_of(input bit use_q);
    longint c = 0, v;
    int m = v_i.size();
    for (int t = 0; t <= STAGES; t++) begin
      v = (m - 1 - t >= 0) ? (use_q ? v_q[m-1-t] : v_i[m-1-t]) : 0;
      c += ((t % 2) ? -1 : 1) * binom(STAGES, t) * v;
    end
    c = (c <<< (64 - W)) >>> (64 - W);
    return c;
  endfunction

  function automatic longint scale_ref(input longint c, input int s);
    longint t = c;
`ifdef CIC_DECIMATOR_ROUND_EN
    t = t + (longint'(1) << (s - 1));
`endif
    t = t >>> s;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  task automatic model_clear();
    hist_i.delete(); hist_q.delete(); v_i.delete(); v_q.delete();
    nstrb = 0;
  endtask

  // Predict the post-edge outputs, then compare them 1 time unit later.
  always begin
    @(posedge clk);
    exp_v = 1'b0;
    if (reset) begin
      model_clear();
      exp_i = '0; exp_q = '0;
    end else if (decim_log2 !== prev_d) begin
      model_clear();
    end else if (in_valid) begin
      hist_i.push_back(longint'(in_i));
      hist_q.push_back(longint'(in_q));
      if (hist_i.size() % (1 << eff_of(decim_log2)) == 0) begin
        v_i.push_back(integ_sum(1'b0));
        v_q.push_back(integ_sum(1'b1));
        nstrb++;
        if (nstrb > STAGES) begin
          exp_v = 1'b1;
          exp_i = DSZ'(scale_ref(comb_of(1'b0), STAGES * eff_of(decim_log2)));
          exp_q = DSZ'(scale_ref(comb_of(1'b1), STAGES * eff_of(decim_log2)));
        end
      end
    end
    prev_d = decim_log2;
    #1;
    checks++;
    if (out_valid !== exp_v || out_i !== exp_i || out_q !== exp_q) begin
      errors++;
      if (errors <= 20)
        $display("FAIL model t=%0t: got v=%0b i=%0d q=%0d want v=%0b i=%0d q=%0d",
                 $time, out_valid, out_i, out_q, exp_v, exp_i, exp_q);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset(input logic [2:0] d);
    decim_log2 = d; reset = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] d;
    logic signed [DSZ-1:0] xi, xq;
    int gap, first_acc, period, exp_i, exp_q;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int acc, first_acc, last_c, per, nval, n, rr, len;
    logic [2:0] d;
    longint got[$];
    longint imp_exp[8];

    tbl[0] = '{3'd3,  16'sd1000,   -16'sd1000,  1, 40,  8,  1000,   -1000};
    tbl[1] = '{3'd6,  16'sd32767,  -16'sd32768, 1, 320, 64, 32767,  -32768};
    tbl[2] = '{3'd2,  16'sd500,    -16'sd500,   2, 20,  8,  500,    -500};
    tbl[3] = '{3'd0,  16'sd300,    -16'sd7,     1, 10,  2,  300,    -7};
    tbl[4] = '{3'd7, -16'sd1234,   16'sd5678,   1, 10,  2,  -1234,  5678};
    tbl[5] = '{3'd5, -16'sd20000,  16'sd12345,  1, 160, 32, -20000, 12345};
    imp_exp = '{0, 0, 0, 0, 256, 1536, 256, 0};

    reset = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0; decim_log2 = 3'd3;
    tick();
    chk("reset_valid", longint'(out_valid), 0);
    chk("reset_out_i", longint'(out_i), 0);
    chk("reset_out_q", longint'(out_q), 0);

    // DC vectors: settling length, output period and settled value.
    for (int k = 0; k < 6; k++) begin
      do_reset(tbl[k].d);
      in_i = tbl[k].xi; in_q = tbl[k].xq;
      rr = 1 << eff_of(tbl[k].d);
      acc = 0; first_acc = -1; last_c = 0; per = -1; nval = 0;
      for (int c = 0; c < (STAGES + 4) * rr * tbl[k].gap; c++) begin
        in_valid = (tbl[k].gap == 1) || (c % 2 == 0);
        tick();
        if (in_valid) acc++;
        if (out_valid) begin
          if (first_acc < 0) first_acc = acc;
          else per = c - last_c;
          last_c = c;
          nval++;
        end
      end
      $display("vec %0d: d=%0d in=(%0d,%0d) out=(%0d,%0d) first_acc=%0d period=%0d",
               k, tbl[k].d, tbl[k].xi, tbl[k].xq, out_i, out_q, first_acc, per);
      chk($sformatf("vec%0d_first_acc", k), first_acc, tbl[k].first_acc);
      chk($sformatf("vec%0d_period", k), per, tbl[k].period);
      chk($sformatf("vec%0d_out_i", k), longint'(out_i), tbl[k].exp_i);
      chk($sformatf("vec%0d_out_q", k), longint'(out_q), tbl[k].exp_q);
    end

    // Rate change 3 -> 1: flush edge, 5 strobes of R=2, then every 2 clks.
    do_reset(3'd3);
    in_i = 16'sd200; in_q = -16'sd200; in_valid = 1'b1;
    repeat (60) tick();
    decim_log2 = 3'd1; n = -1;
    for (int c = 1; c <= 40 && n < 0; c++) begin
      tick();
      if (out_valid) n = c;
    end
    $display("rate change: first valid after %0d clks out_i=%0d", n, out_i);
    chk("rate_first_valid", n, 11);
    chk("rate_out_i", longint'(out_i), 200);
    chk("rate_out_q", longint'(out_q), -200);
    tick(); chk("rate_gap_valid", longint'(out_valid), 0);
    tick(); chk("rate_next_valid", longint'(out_valid), 1);

    // Reset at counter=5 with R=8.
    do_reset(3'd3);
    in_i = 16'sd100; in_q = -16'sd100; in_valid = 1'b1;
    repeat (53) tick();
    chk("pre_reset_out_i", longint'(out_i), 100);
    reset = 1'b1; tick();
    chk("midreset_valid", longint'(out_valid), 0);
    chk("midreset_out_i", longint'(out_i), 0);
    chk("midreset_out_q", longint'(out_q), 0);
    reset = 1'b0; n = -1;
    for (int c = 1; c <= 100 && n < 0; c++) begin
      tick();
      if (out_valid) n = c;
    end
    $display("mid reset: first valid after %0d accepted samples", n);
    chk("midreset_first_valid", n, 40);
    chk("midreset_after_i", longint'(out_i), 100);
    // Reset coinciding with a strobe (counter at 7).
    repeat (7) tick();
    reset = 1'b1; tick();
    chk("reset_vs_strobe_valid", longint'(out_valid), 0);
    reset = 1'b0;

    // Impulse response, R=2: 4096 at sample 13 -> 4096*{1,6,1}/16.
    do_reset(3'd1);
    in_q = '0; in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_i = (c == 13) ? 16'sd4096 : 16'sd0;
      tick();
      if (out_valid) got.push_back(longint'(out_i));
    end
    chk("impulse_count_ge8", longint'(got.size() >= 8), 1);
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      $display("impulse out[%0d]=%0d", k, got[k]);
      chk($sformatf("impulse_%0d", k), got[k], imp_exp[k]);
    end
    // Odd-valued impulse exercises rounding vs truncation via the model.
    for (int c = 0; c < 30; c++) begin
      in_i = (c == 3) ? 16'sd4100 : 16'sd0;
      tick();
    end

    // Randomized traffic: rate, gaps and data random; model checks every clk.
    for (int seg = 0; seg < 10; seg++) begin
      d = 3'($urandom_range(0, 7));
      if (seg % 2 == 0) do_reset(d);
      else decim_log2 = d;
      len = (STAGES + 3) * (1 << eff_of(d)) * 4 / 3 + 20;
      $display("random seg %0d: decim_log2=%0d clks=%0d", seg, d, len);
      for (int c = 0; c < len; c++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_i = DSZ'($urandom);
        in_q = DSZ'($urandom);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 Parameter DSZ, 16, signed I/Q data width in and out.
REQ-002 Parameter STAGES, 4, number of integrator/comb pairs N (1..6).
REQ-003 Parameter LOG2_RMAX, 6, maximum decimation exponent; internal width W = DSZ + STAGES*LOG2_RMAX.
REQ-004 clk  input  1  clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_i  input  DSZ signed  in-phase sample from the quadrature tuner.
REQ-007 in_q  input  DSZ signed  quadrature sample from the quadrature tuner.
REQ-008 in_valid  input  1  input sample strobe; tie high for one sample per clk.
REQ-009 decim_log2  input  3  decimation R = 2^decim_log2; legal 1..LOG2_RMAX.
REQ-010 out_i  output  DSZ signed  decimated in-phase sample.
REQ-011 out_q  output  DSZ signed  decimated quadrature sample.
REQ-012 out_valid  output  1  one-clk pulse per decimated output pair.

Function
REQ-013 The block SHALL implement an N-stage CIC decimator, differential delay 1, identical independent I and Q paths.
REQ-014 Integrators SHALL be W-bit two's-complement registers updated only when in_valid=1; wrap-around is intended and SHALL NOT be saturated.
REQ-015 Integrator stage 1 SHALL accumulate the sign-extended input; stage k SHALL accumulate stage k-1's register value (pipelined, one clk per stage).
REQ-016 A decimation counter SHALL count accepted samples 0..R-1; the strobe SHALL fire on the in_valid cycle where the counter equals R-1, then the counter SHALL return to 0.
REQ-017 On strobe, the last integrator value SHALL pass through N W-bit comb stages (y = x - x_delayed, delays updated only on strobe).
REQ-018 The comb result SHALL be arithmetically right-shifted by STAGES*decim_log2 and reduced to DSZ bits, then registered to out_i/out_q.
REQ-019 out_valid SHALL pulse high exactly 1 clk after the strobe cycle, coincident with the new out_i/out_q; outputs SHALL hold between pulses.
REQ-020 decim_log2 SHALL be sampled every clk; a change from the previously sampled value SHALL clear integrators, comb delays and counter in the following clk (flush).
REQ-021 After reset or flush, out_valid SHALL be suppressed for the first STAGES strobes (settling); outputs SHALL remain at their last value.
REQ-022 Illegal decim_log2 (0 or >LOG2_RMAX) SHALL be treated as 1.
REQ-023 in_valid low SHALL freeze integrators and counter with no effect on pending output.
REQ-024 A reset and strobe in the same clk: reset SHALL win, no out_valid.

Reset
REQ-025 On reset: integrators, comb delays, counter, settling count cleared; out_i=0, out_q=0, out_valid=0.
REQ-026 Reset asserted mid-decimation SHALL discard the partial sample; first output after release requires R accepted samples plus settling.

Configuration
REQ-027 Macro CIC_DECIMATOR_ROUND_EN defined: round half up (add 2^(shift-1) before shift) then saturate to [-2^(DSZ-1), 2^(DSZ-1)-1].
REQ-028 Macro CIC_DECIMATOR_ROUND_EN undefined: truncate (floor) with no rounding adder; saturation still applied.

Verification
REQ-029 DC: in_i=1000, in_q=-1000, in_valid=1, decim_log2=3 -> after 4 suppressed strobes, out_valid every 8 clks, out_i=1000, out_q=-1000.
REQ-030 Full scale: in_i=32767, in_q=-32768, decim_log2=6 -> settled out_i=32767, out_q=-32768, no wrap artefacts.
REQ-031 Gapped input: in_valid 1-of-2 clks, decim_log2=2, DC 500 -> out_valid every 8 clks, out_i=500.
REQ-032 Rate change: decim_log2 3->1 mid-block with DC 200 -> flush, 4 suppressed strobes, then out_valid every 2 clks, out_i=200.
REQ-033 Reset mid-operation at counter=5 (R=8) -> out_valid=0, outputs 0, next valid output only after 8*5 accepted samples.
REQ-034 Impulse: single in_i=4096 then zeros, decim_log2=1, STAGES=4 -> output sequence matches reference CIC impulse response (truncated, and rounded with CIC_DECIMATOR_ROUND_EN).
